// File: rtl/spi_slave_param_if.sv
// Bus bundle between an SPI front end (slave) and whatever drives the serial
// lines and RAM read data (master).
interface spi_slave_param_if #(
  parameter int DATA_W = 8
);
  logic              ss_n;
  logic              mosi;
  logic              miso;
  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              busy;
  logic              frame_err;

  modport slave (
    input  ss_n, mosi, tx_data, tx_valid,
    output miso, rx_data, rx_valid, busy, frame_err
  );

  modport master (
    output ss_n, mosi, tx_data, tx_valid,
    input  miso, rx_data, rx_valid, busy, frame_err
  );
endinterface

// File: rtl/spi_slave_param.sv
// SPI slave front end: deserialises {cmd, payload} frames from MOSI and serialises
// RAM read data back on MISO, with abort and read-data-timeout error pulses.
module spi_slave_param #(
  parameter int DATA_W      = 8,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int TX_WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  spi_slave_param_if.slave bus
);
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CHK_CMD   = 3'd1;
  localparam logic [2:0] ST_WRITE     = 3'd2;
  localparam logic [2:0] ST_READ_ADD  = 3'd3;
  localparam logic [2:0] ST_READ_DATA = 3'd4;

  // Sub-phase inside WRITE/READ_ADD/READ_DATA; HOLD waits for ss_n high.
  localparam logic [1:0] PH_RX   = 2'd0;
  localparam logic [1:0] PH_WAIT = 2'd1;
  localparam logic [1:0] PH_TX   = 2'd2;
  localparam logic [1:0] PH_HOLD = 2'd3;

  localparam int CNT_MAX = (DATA_W + 1 > TX_WAIT_MAX) ? DATA_W + 1 : TX_WAIT_MAX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_TMO  = CNT_W'(TX_WAIT_MAX - 1);

  logic [2:0]        state_q, state_d;
  logic [1:0]        phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              c1_q, c1_d;
  logic              cmd0_q, cmd0_d;
  logic [DATA_W-1:0] pl_q, pl_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic              miso_q, miso_d;
  logic [DATA_W+1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              rd_addr_seen_q, rd_addr_seen_d;

  logic [DATA_W-1:0] pl_shift;
  logic [DATA_W-1:0] tx_src;
  logic              tx_head;
  logic [DATA_W-1:0] tx_rest;

  assign pl_shift = MSB_FIRST ? {pl_q[DATA_W-2:0], bus.mosi} : {bus.mosi, pl_q[DATA_W-1:1]};
  // First MISO bit comes straight from tx_data; later bits from the shift register.
  assign tx_src   = (phase_q == PH_WAIT) ? bus.tx_data : tx_sh_q;
  assign tx_head  = MSB_FIRST ? tx_src[DATA_W-1] : tx_src[0];
  assign tx_rest  = MSB_FIRST ? (tx_src << 1) : (tx_src >> 1);

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    cnt_d          = cnt_q;
    c1_d           = c1_q;
    cmd0_d         = cmd0_q;
    pl_d           = pl_q;
    tx_sh_d        = tx_sh_q;
    miso_d         = miso_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    frame_err_d    = 1'b0;
    rd_addr_seen_d = rd_addr_seen_q;

    case (state_q)
      ST_IDLE: begin
        if (!bus.ss_n) begin
          state_d = ST_CHK_CMD;
        end
      end

      ST_CHK_CMD: begin
        if (bus.ss_n) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end else begin
          c1_d    = bus.mosi;
          cnt_d   = '0;
          phase_d = PH_RX;
          if (!bus.mosi) begin
            state_d = ST_WRITE;
          end else if (rd_addr_seen_q) begin
            state_d = ST_READ_DATA;
          end else begin
            state_d = ST_READ_ADD;
          end
        end
      end

      default: begin
        if (bus.ss_n) begin
          // Abort wins over everything, including a same-edge tx_valid.
          state_d     = ST_IDLE;
          miso_d      = 1'b0;
          frame_err_d = (phase_q != PH_HOLD);
        end else begin
          case (phase_q)
            PH_RX: begin
              if (cnt_q == '0) begin
                cmd0_d = bus.mosi;
              end else begin
                pl_d = pl_shift;
              end
              if (cnt_q == CNT_LAST) begin
                rx_data_d  = {c1_q, cmd0_q, pl_shift};
                rx_valid_d = 1'b1;
                cnt_d      = '0;
                phase_d    = (state_q == ST_READ_DATA) ? PH_WAIT : PH_HOLD;
                if (state_q == ST_READ_ADD) begin
                  rd_addr_seen_d = 1'b1;
                end
              end else begin
                cnt_d = cnt_q + CNT_ONE;
              end
            end

            PH_WAIT: begin
              if (bus.tx_valid) begin
                miso_d  = tx_head;
                tx_sh_d = tx_rest;
                cnt_d   = CNT_ONE;
                phase_d = PH_TX;
              end else if (cnt_q == CNT_TMO) begin
                frame_err_d = 1'b1;
                cnt_d       = '0;
                phase_d     = PH_HOLD;
              end else begin
                cnt_d = cnt_q + CNT_ONE;
              end
            end

            PH_TX: begin
              if (cnt_q == CNT_LAST) begin
                miso_d         = 1'b0;
                phase_d        = PH_HOLD;
                rd_addr_seen_d = 1'b0;
              end else begin
                miso_d  = tx_head;
                tx_sh_d = tx_rest;
                cnt_d   = cnt_q + CNT_ONE;
              end
            end

            default: begin
              miso_d = 1'b0;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      phase_q        <= PH_RX;
      cnt_q          <= '0;
      c1_q           <= 1'b0;
      cmd0_q         <= 1'b0;
      pl_q           <= '0;
      tx_sh_q        <= '0;
      miso_q         <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      frame_err_q    <= 1'b0;
      rd_addr_seen_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      cnt_q          <= cnt_d;
      c1_q           <= c1_d;
      cmd0_q         <= cmd0_d;
      pl_q           <= pl_d;
      tx_sh_q        <= tx_sh_d;
      miso_q         <= miso_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      frame_err_q    <= frame_err_d;
      rd_addr_seen_q <= rd_addr_seen_d;
    end
  end

  assign bus.miso      = miso_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: an 8-bit MSB-first and a 16-bit LSB-first instance
// share one stimulus path; a frame-level model predicts every observed output.
module tb_spi_slave_param;
  localparam int TX_WAIT_MAX = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_slave_param_if #(.DATA_W(8))  bus_a ();
  spi_slave_param_if #(.DATA_W(16)) bus_b ();

  spi_slave_param #(.DATA_W(8), .MSB_FIRST(1'b1), .TX_WAIT_MAX(TX_WAIT_MAX)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  spi_slave_param #(.DATA_W(16), .MSB_FIRST(1'b0), .TX_WAIT_MAX(TX_WAIT_MAX)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  // sel picks which instance sees the stimulus; the other idles with ss_n high.
  bit          sel = 1'b0;
  logic        ss_n_r = 1'b1;
  logic        mosi_r = 1'b0;
  logic        tx_valid_r = 1'b0;
  logic [15:0] tx_data_r = '0;

  assign bus_a.ss_n     = sel ? 1'b1 : ss_n_r;
  assign bus_a.mosi     = mosi_r;
  assign bus_a.tx_valid = sel ? 1'b0 : tx_valid_r;
  assign bus_a.tx_data  = tx_data_r[7:0];
  assign bus_b.ss_n     = sel ? ss_n_r : 1'b1;
  assign bus_b.mosi     = mosi_r;
  assign bus_b.tx_valid = sel ? tx_valid_r : 1'b0;
  assign bus_b.tx_data  = tx_data_r;

  logic        miso_o, rx_valid_o, busy_o, frame_err_o, seen_o;
  logic [17:0] rx_data_o;
  assign miso_o      = sel ? bus_b.miso      : bus_a.miso;
  assign rx_valid_o  = sel ? bus_b.rx_valid  : bus_a.rx_valid;
  assign busy_o      = sel ? bus_b.busy      : bus_a.busy;
  assign frame_err_o = sel ? bus_b.frame_err : bus_a.frame_err;
  assign rx_data_o   = sel ? bus_b.rx_data   : {8'b0, bus_a.rx_data};
  assign seen_o      = sel ? dut_b.rd_addr_seen_q : dut_a.rd_addr_seen_q;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          seen_m [2] = '{1'b0, 1'b0};
  logic [17:0] last_rx_m [2] = '{18'h0, 18'h0};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut=%0d got=%0h expected=%0h t=%0t", tag, sel, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic end_frame();
    ss_n_r     = 1'b1;
    tx_valid_r = 1'b0;
    tick();
    check_eq("busy_end", busy_o, 1'b0);
    check_eq("frame_err_end", frame_err_o, 1'b0);
    check_eq("rx_valid_end", rx_valid_o, 1'b0);
    check_eq("rd_addr_seen", seen_o, seen_m[sel]);
  endtask

  task automatic hold_cycles(input int n);
    for (int h = 0; h < n; h++) begin
      mosi_r     = 1'($urandom);
      tx_valid_r = 1'($urandom);
      tx_data_r  = 16'($urandom);
      tick();
      check_eq("rx_valid_hold", rx_valid_o, 1'b0);
      check_eq("frame_err_hold", frame_err_o, 1'b0);
      check_eq("miso_hold", miso_o, 1'b0);
    end
  endtask

  // nbits < dw+2 aborts the receive; delay 0 withholds tx_valid;
  // tx_abort > 0 ends transmission before that bit, by reset when use_rst is set.
  task automatic run_frame(input logic c1, input logic c0, input logic [15:0] pl,
                           input int nbits, input int delay, input logic [15:0] word,
                           input int tx_abort, input bit use_rst);
    int          dw;
    bit          msb;
    bit          rd_data;
    bit          got_tx;
    logic        b;
    logic [17:0] exp_rx;
    dw      = sel ? 16 : 8;
    msb     = !sel;
    rd_data = c1 && seen_m[sel];
    exp_rx  = (18'(c1) << (dw + 1)) | (18'(c0) << dw) | (18'(pl) & ((18'd1 << dw) - 18'd1));
    $display("frame dut=%0d cmd=%b%b payload=%0h bits=%0d delay=%0d word=%0h tx_abort=%0d rst=%0d",
             sel, c1, c0, pl, nbits, delay, word, tx_abort, use_rst);

    ss_n_r     = 1'b0;
    mosi_r     = 1'($urandom);
    tx_valid_r = 1'($urandom);
    tick();
    check_eq("busy_start", busy_o, 1'b1);
    check_eq("rx_valid_start", rx_valid_o, 1'b0);

    for (int j = 0; j < dw + 2; j++) begin
      if (j == nbits) break;
      if (j == 0)      b = c1;
      else if (j == 1) b = c0;
      else if (msb)    b = pl[dw - 1 - (j - 2)];
      else             b = pl[j - 2];
      mosi_r     = b;
      tx_valid_r = 1'($urandom);
      tx_data_r  = 16'($urandom);
      tick();
      check_eq("rx_valid", rx_valid_o, (j == dw + 1));
      check_eq("frame_err_rx", frame_err_o, 1'b0);
      if (j == dw + 1) check_eq("rx_data", rx_data_o, exp_rx);
    end

    if (nbits < dw + 2) begin
      ss_n_r     = 1'b1;
      tx_valid_r = 1'b0;
      tick();
      check_eq("frame_err_abort", frame_err_o, 1'b1);
      check_eq("rx_valid_abort", rx_valid_o, 1'b0);
      check_eq("busy_abort", busy_o, 1'b0);
      check_eq("rx_data_kept", rx_data_o, last_rx_m[sel]);
      tick();
      check_eq("frame_err_once", frame_err_o, 1'b0);
      check_eq("rd_addr_seen_abort", seen_o, seen_m[sel]);
      return;
    end
    last_rx_m[sel] = exp_rx;

    if (!rd_data) begin
      if (c1) seen_m[sel] = 1'b1;
      hold_cycles($urandom_range(0, 3));
      end_frame();
      return;
    end

    got_tx = 1'b0;
    for (int i = 1; i <= TX_WAIT_MAX; i++) begin
      tx_valid_r = (i == delay);
      tx_data_r  = (i == delay) ? word : 16'($urandom);
      mosi_r     = 1'($urandom);
      tick();
      if (i == delay) begin
        got_tx = 1'b1;
        break;
      end
      check_eq("miso_wait", miso_o, 1'b0);
      check_eq("frame_err_wait", frame_err_o, (i == TX_WAIT_MAX));
    end

    if (!got_tx) begin
      hold_cycles(2);
      end_frame();
      return;
    end

    for (int i = 0; i <= dw; i++) begin
      if (i > 0) begin
        if (i == tx_abort) begin
          ss_n_r     = 1'b1;
          tx_valid_r = 1'b0;
          if (use_rst) begin
            rst = 1'b1;
            tick();
            seen_m    = '{1'b0, 1'b0};
            last_rx_m = '{18'h0, 18'h0};
            check_eq("rst_miso", miso_o, 1'b0);
            check_eq("rst_rx_data", rx_data_o, 18'h0);
            check_eq("rst_rx_valid", rx_valid_o, 1'b0);
            check_eq("rst_busy", busy_o, 1'b0);
            check_eq("rst_frame_err", frame_err_o, 1'b0);
            check_eq("rst_rd_addr_seen", seen_o, 1'b0);
            rst = 1'b0;
            tick();
            check_eq("frame_err_after_rst", frame_err_o, 1'b0);
          end else begin
            tick();
            check_eq("frame_err_tx_abort", frame_err_o, 1'b1);
            check_eq("busy_tx_abort", busy_o, 1'b0);
            check_eq("miso_tx_abort", miso_o, 1'b0);
            tick();
            check_eq("rd_addr_seen_tx_abort", seen_o, 1'b1);
          end
          return;
        end
        tx_valid_r = 1'($urandom);
        tx_data_r  = 16'($urandom);
        tick();
      end
      if (i < dw) check_eq("miso_bit", miso_o, msb ? word[dw - 1 - i] : word[i]);
      else        check_eq("miso_after", miso_o, 1'b0);
      check_eq("frame_err_tx", frame_err_o, 1'b0);
    end
    seen_m[sel] = 1'b0;
    check_eq("rd_addr_seen_cleared", seen_o, 1'b0);
    hold_cycles($urandom_range(0, 2));
    end_frame();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_miso_a", bus_a.miso, 1'b0);
    check_eq("reset_rx_data_a", bus_a.rx_data, 10'h0);
    check_eq("reset_busy_a", bus_a.busy, 1'b0);
    check_eq("reset_frame_err_b", bus_b.frame_err, 1'b0);
    check_eq("reset_rx_valid_b", bus_b.rx_valid, 1'b0);
    rst = 1'b0;
    tick();

    sel = 1'b0;
    run_frame(1'b0, 1'b0, 16'h5A, 99, 1, 16'h0, 0, 1'b0);
    run_frame(1'b1, 1'b0, 16'h3C, 99, 1, 16'h0, 0, 1'b0);
    run_frame(1'b1, 1'b1, 16'h00, 99, 1, 16'hA5, 0, 1'b0);
    run_frame(1'b0, 1'b0, 16'h00, 5, 1, 16'h0, 0, 1'b0);
    run_frame(1'b0, 1'b0, 16'hFF, 99, 1, 16'h0, 0, 1'b0);
    run_frame(1'b1, 1'b0, 16'h11, 99, 1, 16'h0, 0, 1'b0);
    run_frame(1'b1, 1'b1, 16'h22, 99, 0, 16'h0, 0, 1'b0);
    run_frame(1'b1, 1'b1, 16'h33, 99, 14, 16'hC3, 4, 1'b0);
    run_frame(1'b1, 1'b1, 16'h44, 99, 7, 16'h96, 0, 1'b0);

    sel = 1'b1;
    run_frame(1'b1, 1'b0, 16'h0ABC, 99, 1, 16'h0, 0, 1'b0);
    run_frame(1'b1, 1'b1, 16'h0000, 99, 2, 16'h8001, 0, 1'b0);
    run_frame(1'b0, 1'b0, 16'h1234, 99, 1, 16'h0, 0, 1'b0);
    run_frame(1'b1, 1'b0, 16'h00F0, 99, 1, 16'h0, 0, 1'b0);
    run_frame(1'b1, 1'b1, 16'h0F00, 99, 1, 16'h5A5A, 5, 1'b1);

    for (int n = 0; n < 70; n++) begin
      int          dw;
      logic        c1, c0;
      logic [15:0] pl, word;
      int          nbits, delay, tx_abort;
      sel      = ($urandom_range(0, 2) == 0);
      dw       = sel ? 16 : 8;
      c1       = ($urandom_range(0, 3) != 0);
      c0       = 1'($urandom);
      pl       = 16'($urandom);
      word     = 16'($urandom);
      nbits    = ($urandom_range(0, 5) == 0) ? $urandom_range(0, dw + 1) : 99;
      delay    = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TX_WAIT_MAX - 1);
      tx_abort = ($urandom_range(0, 5) == 0) ? $urandom_range(1, dw - 1) : 0;
      run_frame(c1, c0, pl, nbits, delay, word, tx_abort, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_slave_param.md
# spi_slave_param

Parametrised SPI slave front end for the SPI-to-RAM path: deserialises command+payload frames from MOSI into `rx_data` for the RAM controller, then serialises RAM read data back on MISO. Successor to the fixed 8-bit slave with configurable payload width and bit order. Adds explicit frame-abort and read-data-timeout error reporting, and tracks read-address/read-data sequencing internally. The system clock is the bit clock: one MOSI/MISO bit per `clk` cycle while `ss_n` is low.

## Interface
- `DATA_W`, 8, payload width; `rx_data` is `DATA_W+2` bits, `tx_data` is `DATA_W` bits (DATA_W ≥ 2).
- `MSB_FIRST`, 1, 1 = bits shifted MSB first on both MOSI and MISO; 0 = LSB first (command bits still first, see Operation).
- `TX_WAIT_MAX`, 15, max cycles allowed between `rx_valid` of a read-data frame and `tx_valid`.
- `clk`  in  1  system/bit clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ss_n`  in  1  slave select, active low.
- `mosi`  in  1  serial data from master.
- `miso`  out  1  serial data to master, registered.
- `rx_data`  out  DATA_W+2  {cmd[1:0], payload}, valid when `rx_valid`.
- `rx_valid`  out  1  one-cycle pulse, frame received.
- `tx_data`  in  DATA_W  read data from RAM.
- `tx_valid`  in  1  `tx_data` valid, sampled only in READ_DATA wait phase.
- `busy`  out  1  high whenever state ≠ IDLE.
- `frame_err`  out  1  one-cycle pulse on abort or timeout.

## Operation
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: `ss_n` sampled low → CHK_CMD.
- CHK_CMD: samples first bit c1 = cmd[1]; c1=0 → WRITE; c1=1 and `rd_addr_seen`=0 → READ_ADD; c1=1 and `rd_addr_seen`=1 → READ_DATA.
- WRITE/READ_ADD/READ_DATA: shift in remaining DATA_W+1 bits (cmd[0] always next, then payload in order set by MSB_FIRST). After last bit: `rx_data` ← {c1, cmd[0], payload}, `rx_valid` pulses.
- READ_ADD completion sets `rd_addr_seen`; READ_DATA completion of MISO transmission clears it. WRITE leaves it unchanged.
- READ_DATA after `rx_valid`: waits for `tx_valid`; latches `tx_data`; drives DATA_W bits on `miso` (order per MSB_FIRST), then `miso`=0 until frame ends.
- MOSI bits after frame completion ignored; state held until `ss_n` high.
- `ss_n` sampled high in any non-IDLE state → IDLE next cycle. If receive incomplete: `frame_err` pulse, no `rx_valid`, `rd_addr_seen` unchanged. If high during MISO transmission: transmission truncated, `frame_err` pulse, `rd_addr_seen` stays 1.
- Timeout: no `tx_valid` within TX_WAIT_MAX cycles after `rx_valid` → `frame_err` pulse, `miso` held 0, `rd_addr_seen` unchanged, wait for `ss_n` high.
- `tx_valid` outside READ_DATA wait phase ignored.

## Timing
- Reset (`rst` high at edge): state IDLE, `miso`=0, `rx_data`=0, `rx_valid`=0, `busy`=0, `frame_err`=0, `rd_addr_seen`=0, counters 0. `rst` overrides everything, including mid-frame (no `frame_err`).
- `ss_n` low sampled at edge k → CHK_CMD. c1 sampled at k+1; remaining bits at edges k+2 … k+DATA_W+2.
- `rx_valid` high for exactly the cycle after edge k+DATA_W+2; `rx_data` updates on that same edge and holds until next frame completes.
- `tx_valid` sampled high at edge t → first MISO bit visible after edge t; bit i visible after edge t+i; `miso`=0 after edge t+DATA_W.
- `tx_valid` may be high at edge k+DATA_W+2 + 1 earliest; same-edge with `ss_n` high → abort wins.
- Timeout counter starts at 0 after `rx_valid` edge; `frame_err` after edge where count reaches TX_WAIT_MAX.
- `ss_n` high sampled at edge e → IDLE, `busy`=0 after e; new frame may start at e+1.

## Test plan
- DATA_W=8: write frame c1=0, cmd[0]=0, payload 0x5A → `rx_valid` one cycle after 10th bit, `rx_data`=10'h05A, `rd_addr_seen` stays 0.
- Read-address 1,0,0x3C then read-data 1,1,0x00 with `tx_data`=0xA5, `tx_valid` 1 cycle → `rx_data`=10'h23C then 10'h300; MISO 1,0,1,0,0,1,0,1; `rd_addr_seen` 1 then 0.
- `ss_n` raised after 5 bits of write frame → `frame_err` one cycle, no `rx_valid`, next full frame 0x0FF received correctly.
- Read-data frame, `tx_valid` withheld 20 cycles (TX_WAIT_MAX=15) → `frame_err` 15 cycles after `rx_valid`, `miso`=0, `rd_addr_seen` still 1.
- MSB_FIRST=0, DATA_W=16: read-data with `tx_data`=0x8001 → MISO 1 then 14 zeros then 1; write payload 0x1234 LSB first → `rx_data`=18'h01234.
- `rst` asserted mid-MISO transmission → all outputs 0 next cycle, no `frame_err`, `rd_addr_seen`=0.
